rio_frame_unpack: RTL and testbench

RIO_FRAME_UNPACK -- requirements
Module: rio_frame_unpack

---
 rtl/rio_frame_pkg.sv | 36 +++
 rtl/rio_watchdog.sv | 25 ++
 rtl/rio_frame_unpack.sv | 145 ++++++++++++++
 tb/tb_rio_frame_unpack.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rio_frame_pkg.sv
// Shared constants for the RIO frame unpacker: header default, field offsets,
// FSM encoding and reply-status bit positions.
package rio_frame_pkg;

    localparam logic [31:0] MSGID_DEFAULT = 32'h74697277;

    localparam int HDR_W     = 32;
    localparam int JOINT_W   = 32;
    localparam int TRAILER_W = 16;

    // Trailer: dout byte above the flags byte; flags bit0 is the enable request.
    localparam int DOUT_LSB        = 8;
    localparam int FLAGS_LSB       = 0;
    localparam int FLAG_ENABLE_BIT = 0;

    // Reply status byte: {frame_cnt[5:0], enable, timeout}.
    localparam int STATUS_TIMEOUT_BIT = 0;
    localparam int STATUS_ENABLE_BIT  = 1;
    localparam int STATUS_FCNT_LSB    = 2;
    localparam int FCNT_W             = 6;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_UNPACK = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    function automatic int frame_bits(input int joints);
        return HDR_W + JOINT_W * joints + TRAILER_W;
    endfunction

    // Joint 0 sits directly below the header, later joints further down.
    function automatic int joint_lsb(input int buffer_size, input int j);
        return buffer_size - HDR_W - JOINT_W * (j + 1);
    endfunction

endpackage

// File: rtl/rio_watchdog.sv
// Free-running watchdog: counts sysclk cycles since the last kick and
// holds at the limit, flagging expiry while parked there.
module rio_watchdog (
    input  logic        sysclk,
    input  logic        rst,
    input  logic        kick,
    input  logic [31:0] limit,
    output logic        expired
);

    logic [31:0] cnt;

    always_ff @(posedge sysclk) begin
        if (!rst) begin
            cnt <= 32'd0;
        end else if (kick) begin
            cnt <= 32'd0;
        end else if (cnt != limit) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign expired = (cnt == limit);

endmodule

// File: rtl/rio_frame_unpack.sv
// Validates a received command frame, unpacks one joint per cycle and commits
// velocity/dout/enable together with a reply snapshot; a watchdog forces safe outputs.
module rio_frame_unpack
    import rio_frame_pkg::*;
#(
    parameter int          JOINTS      = 3,
    parameter int          BUFFER_SIZE = 144,
    parameter logic [31:0] MSGID       = MSGID_DEFAULT,
    parameter logic [31:0] TIMEOUT     = 32'd4800000
) (
    input  logic                     sysclk,
    input  logic                     rst,
    input  logic [BUFFER_SIZE-1:0]   rx_data,
    input  logic                     rx_stb,
    input  logic [32*JOINTS-1:0]     joint_pos,
    input  logic [7:0]               din,
    output logic [BUFFER_SIZE-1:0]   tx_data,
    output logic [32*JOINTS-1:0]     velocity,
    output logic [7:0]               dout,
    output logic                     enable,
    output logic                     timeout,
    output logic                     commit_stb,
    output logic [7:0]               err_cnt
);

    localparam int IDX_W = (JOINTS > 1) ? $clog2(JOINTS) : 1;

    generate
        if (BUFFER_SIZE != frame_bits(JOINTS)) begin : g_size_check
            $error("rio_frame_unpack: BUFFER_SIZE must equal 48+32*JOINTS");
        end
    endgenerate

    logic [1:0]              state;
    logic [IDX_W-1:0]        idx;
    logic [BUFFER_SIZE-1:0]  shadow;
    logic [32*JOINTS-1:0]    stage_vel;
    logic [FCNT_W-1:0]       frame_cnt;
    logic [BUFFER_SIZE-1:0]  tx_next;
    logic                    commit;
    logic                    hdr_ok;
    logic                    new_enable;
    logic                    check_bad;
    logic                    stray_stb;
    logic [1:0]              err_inc;
    logic [8:0]              err_sum;
    logic                    wd_expired;
    logic                    unused_flags;

    assign commit       = (state == ST_COMMIT);
    assign hdr_ok       = (shadow[BUFFER_SIZE-1 -: HDR_W] == MSGID);
    assign new_enable   = shadow[FLAGS_LSB + FLAG_ENABLE_BIT];
    assign check_bad    = (state == ST_CHECK) && !hdr_ok;
    assign stray_stb    = rx_stb && (state != ST_IDLE);
    assign err_inc      = {1'b0, check_bad} + {1'b0, stray_stb};
    assign err_sum      = {1'b0, err_cnt} + {7'd0, err_inc};
    assign unused_flags = ^shadow[FLAGS_LSB + 1 +: 7];

    rio_watchdog u_watchdog (
        .sysclk  (sysclk),
        .rst     (rst),
        .kick    (commit),
        .limit   (TIMEOUT),
        .expired (wd_expired)
    );

    // Status carries the post-commit frame count and enable, but the timeout
    // seen before this commit, so the host learns a link drop happened.
    always_comb begin
        tx_next = '0;
        tx_next[BUFFER_SIZE-1 -: HDR_W] = MSGID;
        for (int j = 0; j < JOINTS; j++) begin
            tx_next[joint_lsb(BUFFER_SIZE, j) +: JOINT_W] = joint_pos[JOINT_W*j +: JOINT_W];
        end
        tx_next[DOUT_LSB +: 8]                 = din;
        tx_next[STATUS_FCNT_LSB +: FCNT_W]     = frame_cnt + FCNT_W'(1);
        tx_next[STATUS_ENABLE_BIT]             = new_enable;
        tx_next[STATUS_TIMEOUT_BIT]            = timeout;
    end

    always_ff @(posedge sysclk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            shadow     <= '0;
            stage_vel  <= '0;
            velocity   <= '0;
            dout       <= 8'd0;
            enable     <= 1'b0;
            commit_stb <= 1'b0;
            err_cnt    <= 8'd0;
            frame_cnt  <= '0;
            timeout    <= 1'b1;
            tx_data    <= {MSGID, {(BUFFER_SIZE-HDR_W){1'b0}}};
        end else begin
            commit_stb <= 1'b0;
            err_cnt    <= err_sum[8] ? 8'hFF : err_sum[7:0];

            case (state)
                ST_IDLE: begin
                    if (rx_stb) begin
                        shadow <= rx_data;
                        state  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    idx   <= '0;
                    state <= hdr_ok ? ST_UNPACK : ST_IDLE;
                end
                ST_UNPACK: begin
                    for (int j = 0; j < JOINTS; j++) begin
                        if (idx == IDX_W'(j)) begin
                            stage_vel[JOINT_W*j +: JOINT_W] <= shadow[joint_lsb(BUFFER_SIZE, j) +: JOINT_W];
                        end
                    end
                    if (idx == IDX_W'(JOINTS - 1)) begin
                        state <= ST_COMMIT;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_COMMIT: begin
                    velocity   <= new_enable ? stage_vel : '0;
                    dout       <= shadow[DOUT_LSB +: 8];
                    enable     <= new_enable;
                    timeout    <= 1'b0;
                    frame_cnt  <= frame_cnt + FCNT_W'(1);
                    tx_data    <= tx_next;
                    commit_stb <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // A commit in the same cycle as expiry takes precedence.
            if (wd_expired && !commit) begin
                timeout  <= 1'b1;
                velocity <= '0;
                dout     <= 8'd0;
                enable   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rio_frame_unpack.sv
// Directed bench for rio_frame_unpack with JOINTS=3, TIMEOUT=100: a vector
// table for single frames plus hand-written multi-cycle sequences.
module tb_rio_frame_unpack;

    localparam int          JOINTS  = 3;
    localparam int          BS      = 144;
    localparam int          LAT     = 3 + JOINTS;
    localparam logic [31:0] MSGID_C = 32'h74697277;
    localparam logic [31:0] JP0     = 32'h11111111;
    localparam logic [31:0] JP1     = 32'h22222222;
    localparam logic [31:0] JP2     = 32'h33333333;
    localparam logic [7:0]  DIN     = 8'h3C;

    logic            sysclk;
    logic            rst;
    logic [BS-1:0]   rx_data;
    logic            rx_stb;
    logic [95:0]     joint_pos;
    logic [7:0]      din;
    logic [BS-1:0]   tx_data;
    logic [95:0]     velocity;
    logic [7:0]      dout;
    logic            enable;
    logic            timeout;
    logic            commit_stb;
    logic [7:0]      err_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_commit_cyc = 0;
    int n_commits = 0;

    rio_frame_unpack #(
        .JOINTS      (JOINTS),
        .BUFFER_SIZE (BS),
        .MSGID       (MSGID_C),
        .TIMEOUT     (32'd100)
    ) dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_stb     (rx_stb),
        .joint_pos  (joint_pos),
        .din        (din),
        .tx_data    (tx_data),
        .velocity   (velocity),
        .dout       (dout),
        .enable     (enable),
        .timeout    (timeout),
        .commit_stb (commit_stb),
        .err_cnt    (err_cnt)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    typedef struct {
        logic [31:0] hdr;
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [7:0]  fdout;
        logic [7:0]  flags;
        logic        exp_commit;
        logic [95:0] exp_vel;
        logic [7:0]  exp_dout;
        logic        exp_en;
        logic [7:0]  exp_err;
        logic [7:0]  exp_status;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [BS-1:0] act, input logic [BS-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BS-1:0] mk_frame(input logic [31:0] hdr, input logic [31:0] v0,
                                               input logic [31:0] v1, input logic [31:0] v2,
                                               input logic [7:0] fdout, input logic [7:0] flags);
        return {hdr, v0, v1, v2, fdout, flags};
    endfunction

    function automatic logic [BS-1:0] mk_tx(input logic [7:0] status);
        return {MSGID_C, JP0, JP1, JP2, DIN, status};
    endfunction

    // Strobe lands in the current cycle; returns one cycle later.
    task automatic pulse_frame(input logic [BS-1:0] frame);
        rx_data = frame;
        rx_stb  = 1'b1;
        @(posedge sysclk); #1;
        rx_stb  = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sysclk); #1;
        end
    endtask

    // off = cycles after the strobe at which commit_stb was seen, 0 if never.
    task automatic watch_commit(input int start_k, output int off);
        off = 0;
        for (int k = start_k; k <= start_k + 12; k++) begin
            if (commit_stb) begin
                off = k;
                last_commit_cyc = cyc;
                @(posedge sysclk); #1;
                break;
            end
            @(posedge sysclk); #1;
        end
    endtask

    initial begin
        int off;
        int to_cyc;
        int d;

        vecs[0] = '{MSGID_C, 32'h10, 32'hFFFFFFFB, 32'h0, 8'hA5, 8'h01, 1'b1,
                    {32'h0, 32'hFFFFFFFB, 32'h10}, 8'hA5, 1'b1, 8'd0, 8'h07};
        vecs[1] = '{32'hDEADBEEF, 32'h1, 32'h2, 32'h3, 8'hFF, 8'h01, 1'b0,
                    {32'h0, 32'hFFFFFFFB, 32'h10}, 8'hA5, 1'b1, 8'd1, 8'h07};
        vecs[2] = '{MSGID_C, 32'd1000, 32'h7, 32'h9, 8'h5A, 8'h00, 1'b1,
                    96'h0, 8'h5A, 1'b0, 8'd1, 8'h08};
        vecs[3] = '{MSGID_C, 32'h100, 32'h200, 32'h300, 8'h81, 8'hFE, 1'b1,
                    96'h0, 8'h81, 1'b0, 8'd1, 8'h0C};
        vecs[4] = '{MSGID_C, 32'h7FFFFFFF, 32'h80000000, 32'h12345678, 8'h00, 8'h03, 1'b1,
                    {32'h12345678, 32'h80000000, 32'h7FFFFFFF}, 8'h00, 1'b1, 8'd1, 8'h12};
        vecs[5] = '{32'h74697276, 32'h5, 32'h5, 32'h5, 8'hEE, 8'h01, 1'b0,
                    {32'h12345678, 32'h80000000, 32'h7FFFFFFF}, 8'h00, 1'b1, 8'd2, 8'h12};

        rst       = 1'b0;
        rx_stb    = 1'b0;
        rx_data   = '0;
        joint_pos = {JP2, JP1, JP0};
        din       = DIN;
        step(3);

        check("rst_velocity", BS'(velocity), BS'(96'h0));
        check("rst_dout", BS'(dout), BS'(8'h00));
        check("rst_enable", BS'(enable), BS'(1'b0));
        check("rst_commit_stb", BS'(commit_stb), BS'(1'b0));
        check("rst_err_cnt", BS'(err_cnt), BS'(8'h00));
        check("rst_timeout", BS'(timeout), BS'(1'b1));
        check("rst_tx_data", tx_data, {MSGID_C, 112'h0});
        rst = 1'b1;
        step(5);

        for (int i = 0; i < 6; i++) begin
            pulse_frame(mk_frame(vecs[i].hdr, vecs[i].v0, vecs[i].v1, vecs[i].v2,
                                 vecs[i].fdout, vecs[i].flags));
            watch_commit(1, off);
            check($sformatf("vec%0d_commit_cycle", i), BS'(off), BS'(vecs[i].exp_commit ? LAT : 0));
            check($sformatf("vec%0d_velocity", i), BS'(velocity), BS'(vecs[i].exp_vel));
            check($sformatf("vec%0d_dout", i), BS'(dout), BS'(vecs[i].exp_dout));
            check($sformatf("vec%0d_enable", i), BS'(enable), BS'(vecs[i].exp_en));
            check($sformatf("vec%0d_timeout", i), BS'(timeout), BS'(1'b0));
            check($sformatf("vec%0d_err_cnt", i), BS'(err_cnt), BS'(vecs[i].exp_err));
            check($sformatf("vec%0d_tx_data", i), tx_data, mk_tx(vecs[i].exp_status));
            if (vecs[i].exp_commit) n_commits++;
        end

        // Second strobe arrives during UNPACK of the first frame.
        pulse_frame(mk_frame(MSGID_C, 32'h1, 32'h2, 32'h3, 8'h11, 8'h01));
        step(1);
        pulse_frame(mk_frame(MSGID_C, 32'h9, 32'h9, 32'h9, 8'h22, 8'h01));
        watch_commit(3, off);
        n_commits++;
        check("dbl_commit_cycle", BS'(off), BS'(LAT));
        check("dbl_velocity", BS'(velocity), BS'({32'h3, 32'h2, 32'h1}));
        check("dbl_dout", BS'(dout), BS'(8'h11));
        check("dbl_err_cnt", BS'(err_cnt), BS'(8'd3));
        check("dbl_tx_data", tx_data, mk_tx(8'h16));
        watch_commit(1, off);
        check("dbl_no_second_commit", BS'(off), BS'(0));

        // Watchdog expiry after a silent link, then recovery.
        pulse_frame(mk_frame(MSGID_C, 32'h100, 32'h200, 32'h300, 8'h77, 8'h01));
        watch_commit(1, off);
        n_commits++;
        check("wd_commit_cycle", BS'(off), BS'(LAT));
        check("wd_tx_data", tx_data, mk_tx(8'h1A));
        step(49);
        check("wd_not_yet", BS'(timeout), BS'(1'b0));
        check("wd_velocity_held", BS'(velocity), BS'({32'h300, 32'h200, 32'h100}));
        to_cyc = -1000;
        for (int i = 0; i < 100; i++) begin
            if (timeout) begin
                to_cyc = cyc;
                break;
            end
            step(1);
        end
        d = to_cyc - last_commit_cyc;
        check($sformatf("wd_expiry_delay_%0d_in_100_101", d), BS'(d >= 100 && d <= 101), BS'(1'b1));
        check("wd_velocity_zero", BS'(velocity), BS'(96'h0));
        check("wd_dout_zero", BS'(dout), BS'(8'h00));
        check("wd_enable_zero", BS'(enable), BS'(1'b0));
        pulse_frame(mk_frame(MSGID_C, 32'h44, 32'h55, 32'h66, 8'hC3, 8'h01));
        watch_commit(1, off);
        n_commits++;
        check("wd_recover_commit", BS'(off), BS'(LAT));
        check("wd_recover_timeout", BS'(timeout), BS'(1'b0));
        check("wd_recover_velocity", BS'(velocity), BS'({32'h66, 32'h55, 32'h44}));
        check("wd_recover_tx_status", tx_data, mk_tx(8'h1F));

        // Disabled frames up to 64 commits total: frame count wraps to 0.
        while (n_commits < 64) begin
            pulse_frame(mk_frame(MSGID_C, 32'd1000, 32'd1000, 32'd1000, 8'(n_commits), 8'h00));
            watch_commit(1, off);
            n_commits++;
        end
        check("wrap_commit_cycle", BS'(off), BS'(LAT));
        check("wrap_velocity_zero", BS'(velocity), BS'(96'h0));
        check("wrap_enable", BS'(enable), BS'(1'b0));
        check("wrap_dout", BS'(dout), BS'(8'd63));
        check("wrap_tx_data", tx_data, mk_tx(8'h00));

        // Reset in the middle of UNPACK must leave nothing behind.
        pulse_frame(mk_frame(MSGID_C, 32'h1, 32'h1, 32'h1, 8'h99, 8'h01));
        watch_commit(1, off);
        check("pre_rst_enable", BS'(enable), BS'(1'b1));
        pulse_frame(mk_frame(MSGID_C, 32'hAAAA, 32'hBBBB, 32'hCCCC, 8'h5F, 8'h01));
        step(1);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        watch_commit(0, off);
        check("midrst_no_commit", BS'(off), BS'(0));
        check("midrst_velocity", BS'(velocity), BS'(96'h0));
        check("midrst_dout", BS'(dout), BS'(8'h00));
        check("midrst_enable", BS'(enable), BS'(1'b0));
        check("midrst_timeout", BS'(timeout), BS'(1'b1));
        check("midrst_err_cnt", BS'(err_cnt), BS'(8'd0));
        check("midrst_tx_data", tx_data, {MSGID_C, 112'h0});

        // Bad headers saturate the error counter.
        for (int i = 0; i < 254; i++) begin
            pulse_frame(mk_frame(32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 8'h00, 8'h01));
            step(1);
        end
        check("err_254", BS'(err_cnt), BS'(8'd254));
        for (int i = 0; i < 46; i++) begin
            pulse_frame(mk_frame(32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 8'h00, 8'h01));
            step(1);
        end
        check("err_saturated", BS'(err_cnt), BS'(8'd255));
        check("err_outputs_unchanged", BS'(velocity), BS'(96'h0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
